// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the ntt_engine block.
//
// Contents:
//   - state_e: engine state encoding. SCALE exists only when
//     NTT_ENGINE_INVERSE_EN is defined.
//   - DEFAULT_GEN: generator of the multiplicative group mod 65537.
//   - stages():      L = log2(D).
//   - modpow():      modular exponentiation.
//   - modinv():      modular inverse, assuming a prime modulus.
//   - bitrev():      bit reversal.
//   - twiddle():     one bit-reversed twiddle table entry.
//   - default_psi(): the default 2D-th root of unity.
//   - dinv():        D^-1 mod Q.
//
// All functions are intended for elaboration-time constants only.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
`ifdef NTT_ENGINE_INVERSE_EN
        ST_SCALE = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_e;

    // 3 generates the full multiplicative group mod 65537, so 3^((Q-1)/2D)
    // is a primitive 2D-th root of unity for that modulus. For any other Q,
    // PSI must be given explicitly.
    localparam longint unsigned DEFAULT_GEN = 64'd3;

    function automatic int unsigned stages(input int unsigned d);
        return $clog2(d);
    endfunction

    function automatic longint unsigned modpow(input longint unsigned base,
                                               input longint unsigned expo,
                                               input longint unsigned q);
        longint unsigned r;
        longint unsigned b;
        longint unsigned e;
        r = 64'd1 % q;
        b = base % q;
        e = expo;
        while (e != 64'd0) begin
            if (e[0]) r = (r * b) % q;
            b = (b * b) % q;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic longint unsigned modinv(input longint unsigned x,
                                               input longint unsigned q);
        return modpow(x, q - 64'd2, q);
    endfunction

    function automatic int unsigned bitrev(input int unsigned k, input int unsigned l);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < l; i++) begin
            r = (r << 1) | ((k >> i) & 32'd1);
        end
        return r;
    endfunction

    function automatic longint unsigned twiddle(input int unsigned k, input int unsigned l,
                                                input longint unsigned psi,
                                                input longint unsigned q);
        return modpow(psi, 64'(bitrev(k, l)), q);
    endfunction

    function automatic longint unsigned default_psi(input longint unsigned d,
                                                    input longint unsigned q);
        return modpow(DEFAULT_GEN, (q - 64'd1) / (64'd2 * d), q);
    endfunction

    function automatic longint unsigned dinv(input longint unsigned d,
                                             input longint unsigned q);
        return modinv(d, q);
    endfunction

endpackage

// File: rtl/ntt_bfly.sv
// ntt_bfly: one radix-2 butterfly mod Q with forward/inverse select.
//
// Forward (Cooley-Tukey):
//   t     = tw*hi
//   lo_o  = lo + t
//   hi_o  = lo - t
//
// Inverse (Gentleman-Sande):
//   lo_o  = lo + hi
//   hi_o  = (lo - hi)*tw
//
// All results are mod Q. Inputs must already be < Q.
//
// Ports:
//   inverse    : mode select (0 = forward, 1 = inverse).
//   lo_i, hi_i : lane pair.
//   tw_i       : twiddle.
//   lo_o, hi_o : results.
module ntt_bfly #(
    parameter int unsigned N = 17,
    parameter int unsigned Q = 65537
) (
    input  logic         inverse,
    input  logic [N-1:0] lo_i,
    input  logic [N-1:0] hi_i,
    input  logic [N-1:0] tw_i,
    output logic [N-1:0] lo_o,
    output logic [N-1:0] hi_o
);
    localparam logic [N:0]     Q_N1 = (N + 1)'(Q);
    localparam logic [2*N-1:0] Q_2N = (2 * N)'(Q);

    function automatic logic [N-1:0] add_mod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_N1) s = s - Q_N1;
        return s[N-1:0];
    endfunction

    // The N+1-bit difference wraps on borrow; adding Q back brings it into range.
    function automatic logic [N-1:0] sub_mod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (a < b) d = d + Q_N1;
        return d[N-1:0];
    endfunction

    function automatic logic [N-1:0] mul_mod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = ({{N{1'b0}}, a} * {{N{1'b0}}, b}) % Q_2N;
        return p[N-1:0];
    endfunction

    logic [N-1:0] mul_in;
    logic [N-1:0] prod;

    // A single multiplier is shared between the two modes.
    // Forward scales hi; inverse scales the difference lo - hi.
    always_comb begin
        mul_in = inverse ? sub_mod(lo_i, hi_i) : hi_i;
        prod   = mul_mod(mul_in, tw_i);
        lo_o   = inverse ? add_mod(lo_i, hi_i) : add_mod(lo_i, prod);
        hi_o   = inverse ? prod : sub_mod(lo_i, prod);
    end

endmodule

// File: rtl/ntt_engine.sv
// ntt_engine: iterative negacyclic NTT/INTT over D coefficients mod Q.
//
// Operation:
//   - Accepts one polynomial per beat.
//   - Runs L = log2(D) butterfly stages on D registered lanes.
//   - For the inverse, scales by D^-1.
//   - Holds the result until out_ready.
//   - Forward output is in bit-reversed order.
//   - The inverse expects bit-reversed input and returns natural order.
//
// Configuration:
//   NTT_ENGINE_INVERSE_EN enables:
//     - the INTT path,
//     - the inverse twiddle table,
//     - the SCALE state.
//   Without it, in_inverse is ignored.
//
// Ports:
//   clk, rst             : clock; asynchronous active-high reset.
//   in_valid / in_ready  : input handshake.
//   in_inverse           : mode, sampled with the accepted beat.
//   in_data              : D lanes of N bits; lane i at [N*(i+1)-1:N*i].
//   out_valid / out_ready: output handshake.
//   out_data             : result lanes, same packing as in_data.
//   busy                 : high whenever the engine is not idle.
module ntt_engine
    import ntt_pkg::*;
#(
    parameter int unsigned N   = 17,
    parameter int unsigned D   = 8,
    parameter int unsigned Q   = 65537,
    parameter int unsigned PSI = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_inverse,
    input  logic [D*N-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D*N-1:0] out_data,
    output logic           busy
);
    localparam int unsigned     L       = stages(D);
    localparam int unsigned     SW      = $clog2(L + 1);
    localparam int unsigned     P       = D / 2;
    localparam longint unsigned PSI_EFF = (PSI != 0) ? 64'(PSI)
                                                     : default_psi(64'(D), 64'(Q));
    localparam logic [N-1:0]    Q_N     = N'(Q);
    localparam logic [SW-1:0]   S_LAST  = SW'(L - 1);

    state_e        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic          inv_q, inv_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  lane_q [D];
    logic [N-1:0]  lane_d [D];

    logic [N-1:0]  in_lane [D];
    logic [N-1:0]  tw_fwd [D];
    logic          inv_mode;
    logic [SW-1:0] stage;
    logic [L-1:0]  lo_idx [P];
    logic [L-1:0]  hi_idx [P];
    logic [L-1:0]  tw_idx [P];
    logic [N-1:0]  bf_lo_in [P];
    logic [N-1:0]  bf_hi_in [P];
    logic [N-1:0]  bf_tw [P];
    logic [N-1:0]  bf_lo_out [P];
    logic [N-1:0]  bf_hi_out [P];

    for (genvar gi = 0; gi < D; gi++) begin : g_lane
        localparam logic [N-1:0] TW_F = N'(twiddle(gi, L, PSI_EFF, 64'(Q)));
        assign tw_fwd[gi]            = TW_F;
        assign in_lane[gi]           = in_data[N*gi +: N] % Q_N;
        assign out_data[N*gi +: N]   = lane_q[gi];
    end

`ifdef NTT_ENGINE_INVERSE_EN
    localparam longint unsigned PSI_INV = modinv(PSI_EFF, 64'(Q));
    localparam logic [2*N-1:0]  Q_2N    = (2 * N)'(Q);
    localparam logic [2*N-1:0]  DINV_2N = (2 * N)'(dinv(64'(D), 64'(Q)));
    logic [N-1:0] tw_inv [D];
    logic [N-1:0] scaled [D];

    for (genvar gi = 0; gi < D; gi++) begin : g_inv
        localparam logic [N-1:0] TW_I = N'(twiddle(gi, L, PSI_INV, 64'(Q)));
        assign tw_inv[gi] = TW_I;
        assign scaled[gi] = N'(({{N{1'b0}}, lane_q[gi]} * DINV_2N) % Q_2N);
    end
`else
    logic unused_inverse;
    assign unused_inverse = in_inverse;
`endif

    assign inv_mode = inv_q;

    // The counter always runs 0..L-1. The inverse walks the stages in reverse,
    // so the effective stage is mirrored for it.
    // Pair p sits in block p >> h, where h = log2(jump).
    // Its lower lane is p with a zero bit inserted at position h.
    always_comb begin : c_pair
        int unsigned h;
        int unsigned lo;
        h = 0;
        lo = 0;
        stage = inv_mode ? (S_LAST - s_q) : s_q;
        for (int unsigned p = 0; p < P; p++) begin
            h           = L - 1 - 32'(stage);
            lo          = ((p >> h) << (h + 1)) | (p & ((32'd1 << h) - 32'd1));
            lo_idx[p]   = L'(lo);
            hi_idx[p]   = L'(lo + (32'd1 << h));
            tw_idx[p]   = L'((p >> h) + (32'd1 << stage));
            bf_lo_in[p] = lane_q[lo_idx[p]];
            bf_hi_in[p] = lane_q[hi_idx[p]];
`ifdef NTT_ENGINE_INVERSE_EN
            bf_tw[p]    = inv_mode ? tw_inv[tw_idx[p]] : tw_fwd[tw_idx[p]];
`else
            bf_tw[p]    = tw_fwd[tw_idx[p]];
`endif
        end
    end

    for (genvar gi = 0; gi < P; gi++) begin : g_bfly
        ntt_bfly #(.N(N), .Q(Q)) u_bfly (
            .inverse (inv_mode),
            .lo_i    (bf_lo_in[gi]),
            .hi_i    (bf_hi_in[gi]),
            .tw_i    (bf_tw[gi]),
            .lo_o    (bf_lo_out[gi]),
            .hi_o    (bf_hi_out[gi])
        );
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        inv_d       = inv_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        for (int i = 0; i < D; i++) lane_d[i] = lane_q[i];

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int i = 0; i < D; i++) lane_d[i] = in_lane[i];
`ifdef NTT_ENGINE_INVERSE_EN
                    inv_d = in_inverse;
`else
                    inv_d = 1'b0;
`endif
                    s_d        = '0;
                    state_d    = ST_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_RUN: begin
                for (int unsigned p = 0; p < P; p++) begin
                    lane_d[lo_idx[p]] = bf_lo_out[p];
                    lane_d[hi_idx[p]] = bf_hi_out[p];
                end
                if (s_q == S_LAST) begin
`ifdef NTT_ENGINE_INVERSE_EN
                    state_d = inv_q ? ST_SCALE : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
`ifdef NTT_ENGINE_INVERSE_EN
            ST_SCALE: begin
                for (int i = 0; i < D; i++) lane_d[i] = scaled[i];
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                // out_valid is raised one cycle after entering DONE.
                // It drops on the same edge that takes the handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < D; i++) lane_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            for (int i = 0; i < D; i++) lane_q[i] <= lane_d[i];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ntt_engine.sv
`timescale 1ns/1ps
module tb_ntt_engine;
    localparam int N = 17;
    localparam int D = 8;
    localparam int Q = 65537;
    localparam int L = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_inverse = 1'b0;
    logic [D*N-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [D*N-1:0] out_data;
    logic           busy;

    int tests = 0;
    int fails = 0;
    longint unsigned psi;

    ntt_engine #(.N(N), .D(D), .Q(Q), .PSI(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inverse (in_inverse),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned mpow(input longint unsigned b, input longint unsigned e);
        longint unsigned r;
        longint unsigned bb;
        longint unsigned ee;
        r = 1;
        bb = b % Q;
        ee = e;
        while (ee != 0) begin
            if (ee[0]) r = (r * bb) % Q;
            bb = (bb * bb) % Q;
            ee = ee >> 1;
        end
        return r;
    endfunction

    function automatic int brev(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    function automatic logic [D*N-1:0] splat(input int v);
        logic [D*N-1:0] r;
        for (int i = 0; i < D; i++) r[N*i +: N] = N'(v);
        return r;
    endfunction

    function automatic logic [D*N-1:0] delta(input int v);
        logic [D*N-1:0] r;
        r = '0;
        r[N-1:0] = N'(v);
        return r;
    endfunction

    // Direct evaluation: output slot i holds a(psi^(2*brev(i)+1)).
    function automatic logic [D*N-1:0] model_fwd(input logic [D*N-1:0] a);
        logic [D*N-1:0]  r;
        longint unsigned acc;
        longint unsigned w;
        longint unsigned x;
        r = '0;
        for (int i = 0; i < D; i++) begin
            w = mpow(psi, 64'(2 * brev(i) + 1));
            acc = 0;
            x = 1;
            for (int j = 0; j < D; j++) begin
                acc = (acc + 64'(a[N*j +: N]) * x) % Q;
                x = (x * w) % Q;
            end
            r[N*i +: N] = N'(acc);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [D*N-1:0] obs, input logic [D*N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [D*N-1:0] din, input logic inv,
                       output logic [D*N-1:0] dout, output int lat);
        in_data    = din;
        in_inverse = inv;
        in_valid   = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick;
            lat++;
        end
        dout = out_data;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin : main
        logic [D*N-1:0] a;
        logic [D*N-1:0] y;
        logic [D*N-1:0] z;
        int lat;

        psi = mpow(3, 64'((Q - 1) / (2 * D)));

        // Reset values.
        tick;
        tick;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_out_data",  out_data,  0);
        rst = 1'b0;

        // Reset mid-RUN.
        in_data = splat(1234);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        check("midrun_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy",      busy,      0);
        check("midrst_in_ready",  in_ready,  1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data",  out_data,  0);
        tick;
        rst = 1'b0;
        tick;

        // Forward of zeros.
        run('0, 1'b0, y, lat);
        check("zero_lat",      lat, L + 1);
        check("zero_data",     y,   '0);
        check("zero_busy",     busy, 0);
        check("zero_in_ready", in_ready, 1);

        // Forward of scaled deltas.
        run(delta(1), 1'b0, y, lat);
        check("delta1_lat",  lat, L + 1);
        check("delta1_data", y,   splat(1));
        run(delta(5), 1'b0, y, lat);
        check("delta5_data", y, splat(5));

        // Out-of-range input lane: 65537+3 behaves as 3.
        run(delta(Q + 3), 1'b0, y, lat);
        check("oor_data", y, splat(3));
        for (int i = 0; i < D; i++) check("oor_lt_q", (y[N*i +: N] < N'(Q)), 1);

`ifdef NTT_ENGINE_INVERSE_EN
        // Inverse of all-ones.
        run(splat(1), 1'b1, y, lat);
        check("inv_ones_lat",  lat, L + 2);
        check("inv_ones_data", y,   delta(1));
`endif

        // Random vectors: forward vs. direct evaluation, plus round trip.
        for (int v = 0; v < 100; v++) begin
            for (int i = 0; i < D; i++) a[N*i +: N] = N'($urandom_range(0, Q - 1));
            run(a, 1'b0, y, lat);
            check("rand_fwd", y, model_fwd(a));
`ifdef NTT_ENGINE_INVERSE_EN
            run(y, 1'b1, z, lat);
            check("round_trip", z, a);
`endif
        end

        // Back-pressure: hold out_ready low; the second beat must be ignored.
        in_data = delta(5);
        in_inverse = 1'b0;
        in_valid = 1'b1;
        tick;
        in_data = splat(7);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick;
            lat++;
        end
        check("hold_lat", lat, L + 1);
        for (int c = 0; c < 10; c++) begin
            check("hold_data",     out_data,  splat(5));
            check("hold_in_ready", in_ready,  0);
            check("hold_valid",    out_valid, 1);
            tick;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("release_out_valid", out_valid, 0);
        check("release_in_ready",  in_ready,  1);
        check("release_busy",      busy,      0);
        tick;
        check("release_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ntt_engine.md
# ntt_engine

Parametrised, handshaked successor to the flat NTT datapath: one iterative negacyclic NTT/INTT core over D coefficients of N bits modulo Q. It accepts a full polynomial in one beat, runs log2(D) butterfly stages on D registered lanes, optionally scales by D^-1 for the inverse, then holds the result until the consumer takes it. It sits between the polynomial buffer and the pointwise-multiply unit.

## Interface
- N, 17: coefficient width in bits; Q < 2^N.
- D, 8: points per transform; power of two, 4..256.
- Q, 65537: prime modulus, Q ≡ 1 mod 2D.
- PSI, 0: primitive 2D-th root of unity mod Q; 0 selects the package default for Q.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_inverse  in  1  mode sampled with the beat: 0 = NTT, 1 = INTT.
- in_data  in  D*N  coefficients; lane i at [N*(i+1)-1:N*i].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  D*N  result, same lane packing.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, RUN, SCALE, DONE. L = log2(D); stage counter s has ceil(log2(L+1)) bits.
- IDLE: in_ready=1. On in_valid: lane i <= in_data lane mod Q; latch mode; RUN with s=0.
- RUN, forward (Cooley-Tukey): jump = D>>(s+1); lower lane i (bit log2(jump) clear) pairs with i+jump; t = psi_br[(i>>(L-s)) + (1<<s)] * hi mod Q; lo' = lo+t mod Q, hi' = lo−t mod Q.
- RUN, inverse (Gentleman-Sande): stages run s = L−1 down to 0 with the same pairing and index; c = psi_inv_br[idx]; lo' = lo+hi mod Q, hi' = (lo−hi)*c mod Q.
- psi_br[k] = PSI^bitrev_L(k) mod Q; psi_inv_br uses PSI^-1.
- After the last stage: forward → DONE; inverse → SCALE.
- SCALE: every lane <= lane*DINV mod Q, DINV = D^-1 mod Q; → DONE.
- DONE: out_valid=1, out_data = lane registers. When out_ready → IDLE.
- Forward output is bit-reversed; inverse takes bit-reversed input and returns natural order.
- Arithmetic: add/sub use an N+1-bit intermediate with a single conditional ±Q correction; the 2N-bit product is reduced mod Q. All stored lanes are always < Q.

## Timing
- Reset: state=IDLE; lanes, s and latched mode = 0; in_ready=1, out_valid=0, busy=0, out_data=0.
- Accept at edge k. Forward: out_valid rises after edge k+L+1. Inverse: after edge k+L+2.
- With out_ready held high, in_ready returns one cycle after the output handshake. There is no overlap; throughput is one transform per L+3 cycles (forward) or L+4 cycles (inverse).
- out_data is stable while out_valid && !out_ready.
- in_valid is ignored outside IDLE. in_inverse is sampled only at accept.
- Reset mid-transform: immediate return to reset values; the partial result is discarded.

## Configuration
- NTT_ENGINE_INVERSE_EN defined: INTT path, inverse twiddle table and SCALE state are built.
- Not defined: in_inverse is ignored; forward only; no SCALE state and no inverse tables. Forward latency is unchanged.

## Structure
- Package ntt_pkg holds:
  - state enum;
  - L as $clog2(D);
  - functions for modpow, bitrev, twiddle tables and DINV;
  - default PSI for Q=65537.
- Sub-module ntt_bfly (N, Q): one butterfly pair with forward/inverse select. Instantiated D/2 times. Lane pairing and twiddle index are muxed by stage.

## Test plan
- Reset mid-RUN, then in_data all zeros, forward → out_data all zeros after L+1 cycles; busy drops after handshake.
- Forward of lane0=1, others 0 → all lanes 1; lane0=5 → all lanes 5.
- Inverse of all lanes 1 → lane0=1, others 0, valid after L+2 cycles (only with NTT_ENGINE_INVERSE_EN).
- Round trip: 100 random vectors through forward then inverse → the original vector.
- Out-of-range input lane = 65537+3 → treated as 3; all results < Q.
- Hold out_ready=0 for 10 cycles → out_data stable, in_ready=0, second in_valid ignored; release → IDLE.
